// File: rtl/ws_pkg.sv
// Purpose: shared sizing, FSM states and weight-row helper for the 4x4 weight-stationary feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ws_pkg;
  localparam int unsigned bit_width = 8;
  localparam int unsigned N         = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned LOAD_CYC  = N;
  localparam int unsigned DRAIN_CYC = 3 * N - 1;
  localparam int unsigned LCNT_W    = $clog2(LOAD_CYC);
  localparam int unsigned DCNT_W    = $clog2(DRAIN_CYC);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  typedef logic [N*bit_width-1:0]   vec_t;
  typedef logic [N*N*bit_width-1:0] mat_t;

  // Row r of the weight matrix, column c in bits [c*bit_width +: bit_width].
  function automatic vec_t wt_row(input mat_t m, input int unsigned r);
    return m[r*N*bit_width +: N*bit_width];
  endfunction
endpackage

// File: rtl/ws_feeder4x4_if.sv
// Purpose: bundle of the feeder's control, activation handshake and array-facing buses.
// Latency: n/a (wiring only).
// Backpressure: act_valid/act_ready handshake carried here; the feeder drives act_ready.
interface ws_feeder4x4_if;
  import ws_pkg::*;

  logic             start;
  logic [CNT_W-1:0] num_vecs;
  mat_t             wt_matrix;
  logic             act_valid;
  logic             act_ready;
  vec_t             act_vec;
  logic             control;
  vec_t             wt_col;
  vec_t             data_row;
  logic [N-1:0]     row_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, num_vecs, wt_matrix, act_valid, act_vec,
    input  act_ready, control, wt_col, data_row, row_vld, busy, done
  );

  modport slave (
    input  start, num_vecs, wt_matrix, act_valid, act_vec,
    output act_ready, control, wt_col, data_row, row_vld, busy, done
  );
endinterface

// File: rtl/ws_skew_line.sv
// Purpose: DEPTH-stage delay line of {vld, data} that skews one array row.
// Latency: DEPTH cycles from in_* to out_*.
// Backpressure: none; shifts every cycle.
module ws_skew_line #(
  parameter int unsigned bit_width = 8,
  parameter int unsigned DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic [bit_width-1:0] in_dat,
  output logic                 out_vld,
  output logic [bit_width-1:0] out_dat
);
  logic [bit_width:0] stage_q [DEPTH];

  // Shift one stage per cycle; reset empties the whole line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {in_vld, in_dat};
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {out_vld, out_dat} = stage_q[DEPTH-1];
endmodule

// File: rtl/ws_feeder4x4.sv
// Purpose: loads weights into the 4x4 WS array, streams skewed activation rows, then drains.
// Latency: N load cycles; activation a[r] reaches row r 1+r cycles after its handshake.
// Backpressure: act_ready is a registered STREAM flag, independent of act_valid.
module ws_feeder4x4
  import ws_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  ws_feeder4x4_if.slave bus
);
  state_t            state_q, state_d;
  logic [LCNT_W-1:0] load_cnt_q;
  logic [DCNT_W-1:0] drain_cnt_q;
  logic [CNT_W-1:0]  vec_cnt_q;
  logic [CNT_W-1:0]  num_vecs_q;
  mat_t              wt_q;
  logic              act_ready_q;
  logic              hs;
  logic              last_load;
  logic              last_drain;
  logic              last_vec;

  assign hs         = bus.act_valid & act_ready_q;
  assign last_load  = (load_cnt_q == LCNT_W'(LOAD_CYC - 1));
  assign last_drain = (drain_cnt_q == DCNT_W'(DRAIN_CYC - 1));
  // num_vecs_q is non-zero whenever STREAM is reachable, so the minus one cannot underflow there.
  assign last_vec   = hs && (vec_cnt_q == num_vecs_q - CNT_W'(1));

  // Next-state: start only counts in IDLE, so a start coinciding with done is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (last_load) state_d = (num_vecs_q != '0) ? STREAM : DRAIN;
      STREAM:  if (last_vec) state_d = DRAIN;
      DRAIN:   if (last_drain) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; act_ready is registered from the next state so it never sees act_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_ready_q <= (state_d == STREAM);
    end
  end

  // Phase counters and the operands latched with an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      vec_cnt_q   <= '0;
      num_vecs_q  <= '0;
      wt_q        <= '0;
    end else begin
      load_cnt_q  <= (state_q == LOAD)  ? load_cnt_q + LCNT_W'(1)  : '0;
      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DCNT_W'(1) : '0;
      if (state_q == IDLE)
        vec_cnt_q <= '0;
      else if (hs)
        vec_cnt_q <= vec_cnt_q + CNT_W'(1);
      if (state_q == IDLE && bus.start) begin
        num_vecs_q <= bus.num_vecs;
        wt_q       <= bus.wt_matrix;
      end
    end
  end

  // Status and weight-column outputs; the bottom weight row goes first so it shifts deepest.
  always_comb begin
    bus.control   = 1'b0;
    bus.wt_col    = '0;
    bus.act_ready = act_ready_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DRAIN) && last_drain;
    if (state_q == LOAD) begin
      bus.control = 1'b1;
      bus.wt_col  = wt_row(wt_q, (N - 1) - 32'(load_cnt_q));
    end
  end

  // Row r is delayed r+1 cycles; cycles without a handshake inject a zero bubble.
  for (genvar r = 0; r < N; r++) begin : g_row
    logic [bit_width-1:0] lane;
    assign lane = hs ? bus.act_vec[r*bit_width +: bit_width] : '0;
    ws_skew_line #(.bit_width(bit_width), .DEPTH(r + 1)) u_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (hs),
      .in_dat  (lane),
      .out_vld (bus.row_vld[r]),
      .out_dat (bus.data_row[r*bit_width +: bit_width])
    );
  end
endmodule

// File: tb/tb_ws_feeder4x4.sv
// Purpose: randomized and directed checks of ws_feeder4x4 against a cycle-timeline reference model.
// Latency: n/a.
// Backpressure: act_valid driven randomly or by pattern; act_ready taken from the DUT.
module tb_ws_feeder4x4;
  import ws_pkg::*;

  localparam int NI = N;
  localparam int BW = bit_width;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ws_feeder4x4_if bus();
  ws_feeder4x4 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int c0     = 0;
  bit chk_en = 0;

  // Reference timeline: s = cycle start was sampled, d = first drain cycle (-1 while unknown).
  bit   m_act = 0;
  int   m_s, m_d, m_nv, m_hs;
  mat_t m_w;
  vec_t         exp_dr [int];
  logic [N-1:0] exp_rv [int];
  vec_t         src_q [$];

  // Observed array side: per-row received values and shifted-in PE weights.
  int             rcnt [N];
  logic [BW-1:0]  rowbuf [int];
  logic [BW-1:0]  pe_w [N][N];

  // Stimulus driver controls.
  int   vmode = 0;
  bit   vpat [$];
  vec_t vlist [$];
  int   vidx = 0;
  bit   hs_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_ctl(int c);
    return m_act && c >= m_s + 1 && c <= m_s + NI;
  endfunction
  function automatic bit m_ready(int c);
    return m_act && m_nv != 0 && c >= m_s + NI + 1 && (m_d < 0 || c < m_d);
  endfunction
  function automatic bit m_busy(int c);
    return m_act && c >= m_s + 1 && (m_d < 0 || c <= m_d + 3*NI - 2);
  endfunction
  function automatic bit m_done(int c);
    return m_act && m_d >= 0 && c == m_d + 3*NI - 2;
  endfunction
  function automatic vec_t m_wt(int c);
    vec_t v = '0;
    int   k;
    if (m_ctl(c)) begin
      k = c - m_s - 1;
      for (int col = 0; col < NI; col++)
        v[col*BW +: BW] = m_w[((NI-1-k)*NI + col)*BW +: BW];
    end
    return v;
  endfunction

  // Advance the reference at the end of cycle c using the sampled inputs.
  task automatic model_step(input int c);
    vec_t         t_dr;
    logic [N-1:0] t_rv;
    int           key;
    if (!rst_n) begin
      m_act = 0;
      exp_dr.delete();
      exp_rv.delete();
      return;
    end
    if (m_act) begin
      if (m_ready(c) && bus.act_valid) begin
        src_q.push_back(bus.act_vec);
        for (int r = 0; r < NI; r++) begin
          key  = c + 1 + r;
          t_dr = exp_dr.exists(key) ? exp_dr[key] : '0;
          t_rv = exp_rv.exists(key) ? exp_rv[key] : '0;
          t_dr[r*BW +: BW] = bus.act_vec[r*BW +: BW];
          t_rv[r] = 1'b1;
          exp_dr[key] = t_dr;
          exp_rv[key] = t_rv;
        end
        m_hs++;
        if (m_hs == m_nv) m_d = c + 1;
      end
      if (m_done(c)) m_act = 0;
    end else if (bus.start) begin
      m_act = 1;
      m_s   = c;
      m_nv  = int'(bus.num_vecs);
      m_w   = bus.wt_matrix;
      m_hs  = 0;
      m_d   = (m_nv == 0) ? c + NI + 1 : -1;
    end
  endtask

  always @(posedge clk) begin
    model_step(cyc);
    cyc = cyc + 1;
  end

  // Per-cycle compare of every output against the reference, plus array-side capture.
  always @(negedge clk) begin : cmp
    logic [71:0] got, want;
    vec_t        edr;
    logic [N-1:0] erv;
    if (chk_en) begin
      edr  = exp_dr.exists(cyc) ? exp_dr[cyc] : '0;
      erv  = exp_rv.exists(cyc) ? exp_rv[cyc] : '0;
      got  = {bus.control, bus.act_ready, bus.busy, bus.done, bus.row_vld, bus.wt_col, bus.data_row};
      want = {m_ctl(cyc), m_ready(cyc), m_busy(cyc), m_done(cyc), erv, m_wt(cyc), edr};
      check("cycle_outputs", 128'(got), 128'(want));
      for (int r = 0; r < NI; r++) begin
        if (bus.row_vld[r] === 1'b1) begin
          rowbuf[r*4096 + rcnt[r]] = bus.data_row[r*BW +: BW];
          rcnt[r]++;
        end
      end
      if (bus.control === 1'b1) begin
        for (int r = NI-1; r > 0; r--)
          for (int col = 0; col < NI; col++) pe_w[r][col] = pe_w[r-1][col];
        for (int col = 0; col < NI; col++) pe_w[0][col] = bus.wt_col[col*BW +: BW];
      end
    end
  end

  // Activation source: pattern queue first, otherwise off / always / random valid.
  initial begin
    bus.act_valid = 1'b0;
    bus.act_vec   = '0;
    forever begin
      @(negedge clk);
      hs_seen = bus.act_valid & bus.act_ready;
      @(posedge clk);
      #2;
      if (hs_seen) vidx++;
      if (vpat.size() > 0) bus.act_valid = vpat.pop_front();
      else if (vmode == 0) bus.act_valid = 1'b0;
      else if (vmode == 1) bus.act_valid = 1'b1;
      else bus.act_valid = 1'($urandom_range(0, 1));
      bus.act_vec = (vidx < vlist.size()) ? vlist[vidx] : vec_t'($urandom);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int nv, input mat_t w);
    for (int r = 0; r < NI; r++) begin
      rcnt[r] = 0;
      for (int col = 0; col < NI; col++) pe_w[r][col] = '0;
    end
    rowbuf.delete();
    src_q.delete();
    bus.start     = 1'b1;
    bus.num_vecs  = CNT_W'(nv);
    bus.wt_matrix = w;
    c0 = cyc;
    sync();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dc);
    bit seen = 0;
    dc = -1;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1;
        dc = cyc - c0;
      end
    end
    check({tag, "_done_seen"}, 128'(seen), 128'(1));
    sync();
  endtask

  // Rebuild y = a * W from what the array would receive and compare with the source vectors.
  task automatic check_matmul(input string tag);
    int   yr, yd;
    vec_t pw, mw;
    for (int r = 0; r < NI; r++)
      check($sformatf("%s_row%0d_count", tag, r), 128'(rcnt[r]), 128'(src_q.size()));
    for (int r = 0; r < NI; r++) begin
      for (int col = 0; col < NI; col++) begin
        pw[col*BW +: BW] = pe_w[r][col];
        mw[col*BW +: BW] = m_w[(r*NI + col)*BW +: BW];
      end
      check($sformatf("%s_pe_w_row%0d", tag, r), 128'(pw), 128'(mw));
    end
    for (int v = 0; v < src_q.size(); v++) begin
      for (int col = 0; col < NI; col++) begin
        yr = 0;
        yd = 0;
        for (int r = 0; r < NI; r++) begin
          yr += int'(src_q[v][r*BW +: BW]) * int'(m_w[(r*NI + col)*BW +: BW]);
          if (rowbuf.exists(r*4096 + v)) yd += int'(rowbuf[r*4096 + v]) * int'(pe_w[r][col]);
        end
        check($sformatf("%s_y%0d_c%0d", tag, v, col), 128'(yd), 128'(yr));
      end
    end
  endtask

  function automatic mat_t rand_mat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : main
    int         dc;
    int         ndone;
    mat_t       w2;
    logic [7:0] row2_exp [3];
    bit         bub_exp [3];

    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         dc;
    int         ndone;
    mat_t       w2;
    logic [7:0] row2_exp [3];
    bit         bub_exp [3];

    row2_exp[0] = 8'd3;  row2_exp[1] = 8'd7;  row2_exp[2] = 8'd11;
    bub_exp[0]  = 1'b1;  bub_exp[1]  = 1'b0;  bub_exp[2]  = 1'b1;

    // 1: reset held with start asserted
    bus.start = 1'b1; bus.num_vecs = '0; bus.wt_matrix = '0;
    rst_n = 1'b0;
    sync();
    chk_en = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs",
            128'({bus.busy, bus.act_ready, bus.control, bus.done, bus.row_vld, bus.data_row, bus.wt_col}),
            128'(0));
    end
    sync();
    rst_n = 1'b1; bus.start = 1'b0;
    sync();

    // 2: weight load only, W[r][c] = 16r + c
    for (int r = 0; r < NI; r++)
      for (int col = 0; col < NI; col++) w2[(r*NI + col)*BW +: BW] = 8'(16*r + col);
    launch(0, w2);
    @(negedge clk);
    check("t2_ctl_c1", 128'(bus.control), 128'(1));
    check("t2_wt_c1", 128'(bus.wt_col), 128'(32'h33323130));
    repeat (3) @(negedge clk);
    check("t2_wt_c4", 128'(bus.wt_col), 128'(32'h03020100));
    @(negedge clk);
    check("t2_ctl_c5", 128'(bus.control), 128'(0));
    wait_done("t2", dc);
    check("t2_done_cycle", 128'(dc), 128'(15));
    check("t2_pe_row3", 128'({pe_w[3][3], pe_w[3][2], pe_w[3][1], pe_w[3][0]}), 128'(32'h33323130));
    check_matmul("t2");
    @(negedge clk);
    check("t2_idle_busy", 128'(bus.busy), 128'(0));
    sync();

    // 3: three back-to-back vectors
    vlist.delete();
    vlist.push_back(32'h04030201); vlist.push_back(32'h08070605); vlist.push_back(32'h0c0b0a09);
    vidx = 0; vmode = 1;
    launch(3, rand_mat());
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_row2_v%0d", i),
            128'({bus.row_vld[2], bus.data_row[2*BW +: BW]}), 128'({1'b1, row2_exp[i]}));
      @(negedge clk);
    end
    wait_done("t3", dc);
    check("t3_done_cycle", 128'(dc), 128'(18));
    check_matmul("t3");
    vmode = 0; vlist.delete();
    sync();

    // 4: bubble between two vectors
    for (int i = 0; i < 5; i++) vpat.push_back(1'b0);
    vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b1);
    launch(2, rand_mat());
    repeat (5) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 3) check($sformatf("t4_row0_k%0d", k), 128'(bus.row_vld[0]), 128'(bub_exp[k]));
      else       check($sformatf("t4_row3_k%0d", k), 128'(bus.row_vld[3]), 128'(bub_exp[k-3]));
    end
    wait_done("t4", dc);
    check("t4_done_cycle", 128'(dc), 128'(18));
    check_matmul("t4");
    sync();

    // 5: second start during STREAM must be ignored
    vmode = 2;
    launch(5, rand_mat());
    repeat (5) sync();
    bus.start = 1'b1; bus.num_vecs = CNT_W'(1); bus.wt_matrix = rand_mat();
    sync();
    bus.start = 1'b0;
    wait_done("t5", dc);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check("t5_extra_done", 128'(ndone), 128'(0));
    check("t5_row0_vectors", 128'(rcnt[0]), 128'(5));
    check_matmul("t5");
    vmode = 0;
    sync();

    // 6: reset after 2 of 5 vectors, then a clean run
    for (int i = 0; i < 5; i++) vpat.push_back(1'b0);
    vpat.push_back(1'b1); vpat.push_back(1'b1); vpat.push_back(1'b0);
    launch(5, rand_mat());
    repeat (6) sync();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_after_reset",
          128'({bus.busy, bus.act_ready, bus.control, bus.done, bus.row_vld, bus.data_row}), 128'(0));
    sync();
    rst_n = 1'b1;
    sync();
    vmode = 1;
    launch(2, rand_mat());
    wait_done("t6", dc);
    check("t6_done_cycle", 128'(dc), 128'(17));
    check_matmul("t6");
    vmode = 0;
    sync();

    // Randomized runs
    for (int run = 0; run < 4; run++) begin
      vmode = 2;
      launch($urandom_range(1, 6), rand_mat());
      wait_done($sformatf("rnd%0d", run), dc);
      check_matmul($sformatf("rnd%0d", run));
      vmode = 0;
      repeat ($urandom_range(1, 3)) sync();
    end

    repeat (4) sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
